// File: rtl/regfile_sb_pkg.sv
// Shared register-file constants: data width and architectural register indexing.
`ifndef XLEN
`define XLEN 64
`endif

package regfile_sb_pkg;
   localparam int XLEN      = `XLEN;
   localparam int REG_IDX_W = 5;
   localparam int NREG      = 32;
endpackage

// File: rtl/regfile_sb_if.sv
// Writeback, decode-read and issue/flush signals between the pipeline and the register file.
import regfile_sb_pkg::*;

interface regfile_sb_if #(
   parameter int XLEN = `XLEN
);
   // No valid/ready handshake here: every input is qualified by its own
   // enable (wb_wren_i, issue_valid_i, flush_i) and acts on the next rising edge;
   // read data and busy flags are combinational, zero-latency responses.
   logic                 wb_wren_i;
   logic [REG_IDX_W-1:0] wb_idx_i;
   logic [XLEN-1:0]      wb_data_i;
   logic [REG_IDX_W-1:0] rs1_idx_i;
   logic [REG_IDX_W-1:0] rs2_idx_i;
   logic [XLEN-1:0]      rs1_data_o;
   logic [XLEN-1:0]      rs2_data_o;
   logic                 issue_valid_i;
   logic [REG_IDX_W-1:0] issue_rd_idx_i;
   logic                 flush_i;
   logic                 rs1_busy_o;
   logic                 rs2_busy_o;

   modport master (
      output wb_wren_i, wb_idx_i, wb_data_i, rs1_idx_i, rs2_idx_i,
      output issue_valid_i, issue_rd_idx_i, flush_i,
      input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o
   );

   modport slave (
      input  wb_wren_i, wb_idx_i, wb_data_i, rs1_idx_i, rs2_idx_i,
      input  issue_valid_i, issue_rd_idx_i, flush_i,
      output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o
   );
endinterface

// File: rtl/regfile_sb_rf_bypass_read.sv
// One read port: x0 mask, write-first bypass of writeback data, busy masking.
import regfile_sb_pkg::*;

module rf_bypass_read #(
   parameter int XLEN = `XLEN
) (
   input  logic [REG_IDX_W-1:0] rs_idx_i,
   input  logic [XLEN-1:0]      reg_data_i,
   input  logic                 busy_i,
   input  logic                 wb_wren_i,
   input  logic [REG_IDX_W-1:0] wb_idx_i,
   input  logic [XLEN-1:0]      wb_data_i,
   output logic [XLEN-1:0]      rs_data_o,
   output logic                 rs_busy_o
);
   logic is_x0;
   logic wb_hit;

   assign is_x0  = (rs_idx_i == '0);
   assign wb_hit = wb_wren_i && (wb_idx_i == rs_idx_i);

   always_comb begin
      rs_data_o = reg_data_i;
      rs_busy_o = busy_i;
      if (is_x0) begin
         rs_data_o = '0;
         rs_busy_o = 1'b0;
      end else if (wb_hit) begin
         // The producer retires this cycle, so its result is forwarded and the hazard is gone.
         rs_data_o = wb_data_i;
         rs_busy_o = 1'b0;
      end
   end
endmodule

// File: rtl/regfile_sb.sv
// Integer register file x1..x31 with write-first bypass and a RAW-hazard scoreboard.
import regfile_sb_pkg::*;

module regfile_sb #(
   parameter int XLEN = `XLEN,
   parameter int NREG = 32
) (
   input logic         clk,
   input logic         rst,
   regfile_sb_if.slave rf
);
   logic [XLEN-1:0] regs_q [1:NREG-1];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            wb_we;
   logic [XLEN-1:0] rs1_raw;
   logic [XLEN-1:0] rs2_raw;

   assign wb_we = rf.wb_wren_i && (rf.wb_idx_i != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
      end else if (wb_we) begin
         regs_q[rf.wb_idx_i] <= rf.wb_data_i;
      end
   end

   // Clear on writeback first so a same-edge issue to that index re-marks it busy.
   always_comb begin
      busy_d = busy_q;
      if (wb_we) busy_d[rf.wb_idx_i] = 1'b0;
      if (rf.flush_i) begin
         busy_d = '0;
      end else if (rf.issue_valid_i && (rf.issue_rd_idx_i != '0)) begin
         busy_d[rf.issue_rd_idx_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   // x0 has no storage; the read ports mask it anyway, this just avoids an out-of-range read.
   assign rs1_raw = (rf.rs1_idx_i == '0) ? '0 : regs_q[rf.rs1_idx_i];
   assign rs2_raw = (rf.rs2_idx_i == '0) ? '0 : regs_q[rf.rs2_idx_i];

   rf_bypass_read #(.XLEN(XLEN)) u_rd1 (
      .rs_idx_i   (rf.rs1_idx_i),
      .reg_data_i (rs1_raw),
      .busy_i     (busy_q[rf.rs1_idx_i]),
      .wb_wren_i  (rf.wb_wren_i),
      .wb_idx_i   (rf.wb_idx_i),
      .wb_data_i  (rf.wb_data_i),
      .rs_data_o  (rf.rs1_data_o),
      .rs_busy_o  (rf.rs1_busy_o)
   );

   rf_bypass_read #(.XLEN(XLEN)) u_rd2 (
      .rs_idx_i   (rf.rs2_idx_i),
      .reg_data_i (rs2_raw),
      .busy_i     (busy_q[rf.rs2_idx_i]),
      .wb_wren_i  (rf.wb_wren_i),
      .wb_idx_i   (rf.wb_idx_i),
      .wb_data_i  (rf.wb_data_i),
      .rs_data_o  (rf.rs2_data_o),
      .rs_busy_o  (rf.rs2_busy_o)
   );
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter: XLEN, default `XLEN (64), sets the register data width.
REQ-002 Parameter: NREG, default 32, sets the number of architectural integer registers; the index width is 5.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wb_wren_i  input  1  writeback write enable from the writeback stage.
REQ-006 wb_idx_i  input  5  writeback destination register (instr[11:7] of the retiring instruction).
REQ-007 wb_data_i  input  XLEN  writeback data (ALU, load, or CSR result).
REQ-008 rs1_idx_i, rs2_idx_i  input  5 each  decode-stage source indices.
REQ-009 rs1_data_o, rs2_data_o  output  XLEN each  source operand data.
REQ-010 issue_valid_i  input  1  an instruction with a destination register leaves decode this cycle.
REQ-011 issue_rd_idx_i  input  5  destination register of the issuing instruction.
REQ-012 flush_i  input  1  pipeline flush; clears all pending-write marks.
REQ-013 rs1_busy_o, rs2_busy_o  output  1 each  source has an outstanding write (RAW hazard; decode stalls).

Function
REQ-014 Storage SHALL be 31 XLEN-bit registers x1..x31; x0 SHALL have no storage, SHALL read 0, and SHALL ignore writes.
REQ-015 On each rising edge with wb_wren_i=1 and wb_idx_i!=0, regs[wb_idx_i] SHALL take wb_data_i.
REQ-016 Reads SHALL be combinational, with zero latency.
REQ-017 Write-first bypass: if wb_wren_i=1, wb_idx_i!=0, and wb_idx_i==rsN_idx_i, then rsN_data_o SHALL equal wb_data_i in the same cycle.
REQ-018 Scoreboard busy[31:1]: on an edge, issue_valid_i=1 with issue_rd_idx_i!=0 SHALL set busy[issue_rd_idx_i].
REQ-019 On an edge, wb_wren_i=1 with wb_idx_i!=0 SHALL clear busy[wb_idx_i].
REQ-020 If issue and writeback target the same index on the same edge, the set SHALL win, so the entry stays busy for the new producer.
REQ-021 On an edge with flush_i=1, all busy bits SHALL clear, and any same-cycle issue SHALL be ignored; a same-cycle register write SHALL still occur.
REQ-022 rsN_busy_o SHALL equal busy[rsN_idx_i] AND NOT (wb_wren_i AND wb_idx_i==rsN_idx_i); it SHALL always be 0 for index 0.
REQ-023 Each busy bit marks one outstanding producer; the pipeline guarantees that no second issue to a busy rd occurs without a stall. This SHALL NOT be checked in RTL.

Reset
REQ-024 While rst=1 at an edge, all of x1..x31 SHALL become 0, all busy bits SHALL become 0, and any concurrent write or issue SHALL be discarded.
REQ-025 After reset, rs1_data_o, rs2_data_o, rs1_busy_o, and rs2_busy_o SHALL all read 0 until the first write or issue.

Structure
REQ-026 XLEN and the register-index width (5) SHALL come from the shared defines file; no new package types are needed.
REQ-027 The block SHALL contain one sub-module, rf_bypass_read, instantiated once per read port; it performs index compare, the x0 mask, and the data/busy mux.
REQ-028 The block SHALL be instantiated between the writeback-stage outputs (rd_idx/rd_data plus its enable) and the decode stage.

Verification
REQ-029 Scenario 1: reset; write x5=0xDEAD_BEEF; next cycle read rs1=5 -> rs1_data_o=0xDEADBEEF, rs1_busy_o=0.
REQ-030 Scenario 2: write x0=0x1234 with wb_wren_i=1, rs2=0 in the same and following cycles -> rs2_data_o=0 throughout, rs2_busy_o=0.
REQ-031 Scenario 3: x7 holds 0x11; same cycle wb x7=0x22 with rs1=7 -> rs1_data_o=0x22 that cycle, and 0x22 thereafter.
REQ-032 Scenario 4: issue rd=9; next cycle rs2=9 -> busy=1; cycle of wb x9=0x55 -> busy=0 and data=0x55; with simultaneous issue rd=9 -> busy=1 on the following cycle.
REQ-033 Scenario 5: issue rd=3, 4, 6; flush_i=1 together with issue rd=8 -> busy for 3, 4, 6, 8 all 0 next cycle.
REQ-034 Scenario 6: x10=0xAA, busy[10]=1; assert rst together with wb x10=0xBB -> x10 reads 0 and busy=0 after the edge.
